// File: rtl/frame_scan_driver.sv
// Raster timing master: pixel/line counters, pipeline-aligned syncs and data enable, per-frame descriptor snapshot.
// Counters registered (0 clk); syncs/enable lag the counters by PIPE_DELAY clocks; pix_en=0 freezes raster while the delay line drains.
module frame_scan_driver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [87:0] entity_bus_in,
    input  logic        colour_in,
    output logic [9:0]  counter_H,
    output logic [9:0]  counter_V,
    output logic [87:0] entity_bus_out,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic        pixel_out,
    output logic        frame_start,
    output logic        line_end
);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [87:0] ent_q, ent_d;
    logic        fs_q, fs_d;
    scan_t [PIPE_DELAY-1:0] pipe_q;
    scan_t       raw;
    logic        h_last, v_last, wrap;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign wrap   = pix_en && h_last && v_last;

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        ent_d = ent_q;
        fs_d  = fs_q;
        if (pix_en) begin
            fs_d = wrap;
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            // Snapshot lands on the same edge the raster returns to (0,0).
            if (wrap) begin
                ent_d = entity_bus_in;
            end
        end
    end

    always_comb begin
        raw.hs = !((h_q >= HS_START) && (h_q < HS_END));
        raw.vs = !((v_q >= VS_START) && (v_q < VS_END));
        raw.de = (h_q < H_VIS) && (v_q < V_VIS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q   <= '0;
            v_q   <= '0;
            ent_q <= '1;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            ent_q <= ent_d;
            fs_q  <= fs_d;
        end
    end

    // Delay line runs every clock so it drains to the held position during stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= SCAN_IDLE;
            end
        end else begin
            pipe_q[0] <= raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign counter_H      = h_q;
    assign counter_V      = v_q;
    assign entity_bus_out = ent_q;
    assign frame_start    = fs_q;
    assign hsync          = pipe_q[PIPE_DELAY-1].hs;
    assign vsync          = pipe_q[PIPE_DELAY-1].vs;
    assign display_on     = pipe_q[PIPE_DELAY-1].de;
    assign pixel_out      = colour_in & display_on;
    assign line_end       = pix_en && h_last;

endmodule

// File: tb/tb_frame_scan_driver.sv
// Directed bench for frame_scan_driver: 800-pixel lines, 30-line frames, 3-clock renderer latency.
module tb_frame_scan_driver;

    localparam logic [87:0] E1 = 88'h0123456789ABCDEF012345;
    localparam logic [87:0] E2 = 88'hFEDCBA9876543210AA55C3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic [87:0] entity_bus_in = '0;
    logic        colour_in = 1'b0;
    logic [9:0]  counter_H, counter_V;
    logic [87:0] entity_bus_out;
    logic        hsync, vsync, display_on, pixel_out, frame_start, line_end;

    always #5 clk = ~clk;

    frame_scan_driver #(
        .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
        .PIPE_DELAY(3)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .entity_bus_in(entity_bus_in), .colour_in(colour_in),
        .counter_H(counter_H), .counter_V(counter_V),
        .entity_bus_out(entity_bus_out),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .pixel_out(pixel_out), .frame_start(frame_start), .line_end(line_end)
    );

    // mask bits: 0 H, 1 V, 2 hsync, 3 vsync, 4 display_on, 5 pixel_out, 6 frame_start, 7 line_end, 8 entity
    typedef struct {
        string       name;
        logic [8:0]  mask;
        logic [9:0]  h, v;
        logic        hs, vs, de, px, fs, le;
        logic [87:0] ent;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   P = 0;
    bit   colour_mode = 1'b0;

    function automatic exp_t blank(string n);
        exp_t e;
        e.name = n; e.mask = '0; e.h = '0; e.v = '0;
        e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0; e.px = 1'b0;
        e.fs = 1'b0; e.le = 1'b0; e.ent = '0;
        return e;
    endfunction

    task automatic exp_pos(string n, int h, int v);
        exp_t e = blank(n);
        e.mask = 9'h003; e.h = 10'(h); e.v = 10'(v);
        sb.push_back(e);
    endtask

    task automatic exp_de(string n, bit de, bit px);
        exp_t e = blank(n);
        e.mask = 9'h030; e.de = de; e.px = px;
        sb.push_back(e);
    endtask

    task automatic exp_sync(string n, bit hs, bit vs);
        exp_t e = blank(n);
        e.mask = 9'h00C; e.hs = hs; e.vs = vs;
        sb.push_back(e);
    endtask

    task automatic exp_flag(string n, bit fs, bit le);
        exp_t e = blank(n);
        e.mask = 9'h0C0; e.fs = fs; e.le = le;
        sb.push_back(e);
    endtask

    task automatic exp_ent(string n, logic [87:0] ent);
        exp_t e = blank(n);
        e.mask = 9'h100; e.ent = ent;
        sb.push_back(e);
    endtask

    task automatic exp_reset(string n);
        exp_t e = blank(n);
        e.mask = 9'h1FF; e.hs = 1'b1; e.vs = 1'b1; e.ent = '1;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pix_en) P++;
        if (colour_mode) colour_in = (P >= 3) && ((P - 3) % 800 == 0);
    endtask

    task automatic run_to(int target);
        while (P < target) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            bad = 1'b0;
            if (e.mask[0] && counter_H !== e.h) begin
                $display("FAIL %s counter_H got %0d want %0d", e.name, counter_H, e.h); bad = 1'b1;
            end
            if (e.mask[1] && counter_V !== e.v) begin
                $display("FAIL %s counter_V got %0d want %0d", e.name, counter_V, e.v); bad = 1'b1;
            end
            if (e.mask[2] && hsync !== e.hs) begin
                $display("FAIL %s hsync got %b want %b", e.name, hsync, e.hs); bad = 1'b1;
            end
            if (e.mask[3] && vsync !== e.vs) begin
                $display("FAIL %s vsync got %b want %b", e.name, vsync, e.vs); bad = 1'b1;
            end
            if (e.mask[4] && display_on !== e.de) begin
                $display("FAIL %s display_on got %b want %b", e.name, display_on, e.de); bad = 1'b1;
            end
            if (e.mask[5] && pixel_out !== e.px) begin
                $display("FAIL %s pixel_out got %b want %b", e.name, pixel_out, e.px); bad = 1'b1;
            end
            if (e.mask[6] && frame_start !== e.fs) begin
                $display("FAIL %s frame_start got %b want %b", e.name, frame_start, e.fs); bad = 1'b1;
            end
            if (e.mask[7] && line_end !== e.le) begin
                $display("FAIL %s line_end got %b want %b", e.name, line_end, e.le); bad = 1'b1;
            end
            if (e.mask[8] && entity_bus_out !== e.ent) begin
                $display("FAIL %s entity_bus_out got %h want %h", e.name, entity_bus_out, e.ent); bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    initial begin
        logic [95:0] rnd;
        rnd = {$urandom(), $urandom(), $urandom()};
        entity_bus_in = rnd[87:0];
        colour_in = 1'b1;

        // Power-on reset, then a mid-frame asynchronous reset with colour held high.
        repeat (3) @(posedge clk);
        #1;
        exp_reset("por");
        reset = 1'b1;
        pix_en = 1'b1;
        repeat (1000) step();
        exp_pos("pre_reset_pos", 200, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_reset("mid_frame_reset");

        @(posedge clk);
        #1;
        reset = 1'b1;
        colour_in = 1'b0;
        colour_mode = 1'b1;
        P = 0;
        exp_pos("release_pos", 0, 0);
        exp_flag("release_flags", 1'b0, 1'b0);

        step();
        exp_pos("first_step", 1, 0);
        exp_flag("no_fs_after_release", 1'b0, 1'b0);
        run_to(2);   exp_de("de_before_latency", 1'b0, 1'b0);
        run_to(3);   exp_de("de_at_latency", 1'b1, 1'b1);
                     exp_sync("sync_idle_line0", 1'b1, 1'b1);
        run_to(4);   exp_de("pix_col1", 1'b1, 1'b0);
        run_to(642); exp_de("de_last_visible", 1'b1, 1'b0);
        run_to(643); exp_de("de_blank", 1'b0, 1'b0);
        run_to(658); exp_sync("hs_before_fall", 1'b1, 1'b1);
        run_to(659); exp_sync("hs_fall", 1'b0, 1'b1);
        run_to(754); exp_sync("hs_last_low", 1'b0, 1'b1);
        run_to(755); exp_sync("hs_rise", 1'b1, 1'b1);
        run_to(798); exp_flag("le_col798", 1'b0, 1'b0);
        run_to(799); exp_flag("le_col799", 1'b0, 1'b1);
                     exp_pos("last_col", 799, 0);
        run_to(800); exp_pos("next_line", 0, 1);
                     exp_flag("le_after_wrap", 1'b0, 1'b0);
        run_to(803); exp_de("pix_line1_col0", 1'b1, 1'b1);

        // Stall at (320,10): counters hold, enable stays high, resume advances by one.
        run_to(8320);
        exp_pos("stall_entry", 320, 10);
        pix_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_pos("stall_hold", 320, 10);
            exp_de("stall_de", 1'b1, 1'b0);
        end
        pix_en = 1'b1;
        step();
        exp_pos("stall_resume", 321, 10);

        run_to(9600);
        exp_ent("snap_before_change", '1);
        entity_bus_in = E1;
        run_to(15203); exp_de("pix_last_visible_line", 1'b1, 1'b1);
        run_to(16003); exp_de("pix_blank_line", 1'b0, 1'b0);
        run_to(18402); exp_sync("vs_before_fall", 1'b1, 1'b1);
        run_to(18403); exp_sync("vs_fall", 1'b1, 1'b0);
        run_to(20002); exp_sync("vs_last_low", 1'b1, 1'b0);
        run_to(20003); exp_sync("vs_rise", 1'b1, 1'b1);
        run_to(23999);
        exp_pos("frame_last", 799, 29);
        exp_flag("frame_last_flags", 1'b0, 1'b1);
        exp_ent("snap_held_to_wrap", '1);
        run_to(24000);
        exp_pos("frame_wrap", 0, 0);
        exp_flag("frame_start_1", 1'b1, 1'b0);
        exp_ent("snap_loaded_1", E1);
        run_to(24001);
        exp_flag("frame_start_clear", 1'b0, 1'b0);

        run_to(33600);
        entity_bus_in = E2;
        exp_ent("snap_mid_frame_2", E1);
        run_to(47999);
        exp_ent("snap_held_frame_2", E1);
        exp_flag("frame2_last_flags", 1'b0, 1'b1);
        run_to(48000);
        exp_pos("frame_wrap_2", 0, 0);
        exp_flag("frame_start_2", 1'b1, 1'b0);
        exp_ent("snap_loaded_2", E2);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_scan_driver.md
# frame_scan_driver

Scan-timing master for the frame-buffer renderer: generates the `counter_H`/`counter_V` raster position the renderer consumes and produces VGA `hsync`/`vsync`. Also produces a data-enable delayed to match the renderer's pipeline latency, and gates the renderer's returned `colour` into the final pixel. Holds a per-frame snapshot of the entity descriptor bus, so the renderer sees descriptors that stay stable for a whole frame.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch
- `PIPE_DELAY`, 2, renderer latency in clocks from counter change to `colour_in` (≥1)

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  advance raster by one pixel this clock
- `entity_bus_in`  in  88  live descriptors: {entity_8_Flip[13:0], entity_7_Array[17:0], entity_6, entity_5, entity_4, entity_1}, entity_1 at [13:0]
- `colour_in`  in  1  renderer colour (1 = white)
- `counter_H`  out  10  current pixel column, 0..H_TOTAL-1
- `counter_V`  out  10  current line, 0..V_TOTAL-1
- `entity_bus_out`  out  88  frame-stable descriptor snapshot, same packing
- `hsync`  out  1  active-low, pipeline-aligned
- `vsync`  out  1  active-low, pipeline-aligned
- `display_on`  out  1  pipeline-aligned data enable
- `pixel_out`  out  1  `colour_in & display_on`
- `frame_start`  out  1  one-clock pulse at raster (0,0)
- `line_end`  out  1  one-clock pulse on last column

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Compare at 10 bits.
- Counters update only when `pix_en`=1. On the last column (counter_H = H_TOTAL-1), counter_H wraps to 0 and counter_V increments. On the last column of the last line, both wrap to 0.
- Raw (undelayed) signals are computed from the registered counters:
  - hs_raw = 0 iff H_ACTIVE+H_FRONT ≤ counter_H < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 iff V_ACTIVE+V_FRONT ≤ counter_V < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - de_raw = (counter_H < H_ACTIVE) && (counter_V < V_ACTIVE).
- Delay line: a PIPE_DELAY-deep shift register of {hs_raw, vs_raw, de_raw}. It shifts every clock regardless of `pix_en`. Outputs `hsync`, `vsync` and `display_on` come from its last stage.
- `pixel_out` is combinational: `colour_in & display_on`.
- Entity snapshot: `entity_bus_out` loads `entity_bus_in` on the same edge the counters wrap to (0,0). It holds otherwise, so mid-frame input changes are invisible until the next frame.
- `frame_start` is registered. It is 1 for exactly the clock in which the counters first show (0,0) after a wrap; it does not assert on reset release.
- `line_end` = `pix_en && counter_H == H_TOTAL-1` (combinational).

## Timing
- Reset (async assert, sync-released use):
  - counter_H = counter_V = 0.
  - Every delay stage = {1,1,0}, so `hsync`=1, `vsync`=1, `display_on`=0 and `pixel_out`=0.
  - `frame_start`=0.
  - `entity_bus_out` = all ones (every entity ID 4'hF, i.e. unused).
  - `line_end` follows its equation.
- Reset mid-line/mid-frame: all of the above take effect immediately. The raster restarts at (0,0) with no `frame_start` pulse and no snapshot load until the first natural wrap.
- Latency:
  - Counter → `counter_H`/`counter_V` is 0 extra clocks (registered outputs).
  - Counter value at clock n → `hsync`/`vsync`/`display_on` at clock n+PIPE_DELAY.
- With `pix_en` held low, counters, snapshot and `frame_start` freeze. The delay line still drains, so after PIPE_DELAY clocks its outputs reflect the held raster position.
- Simultaneous wrap and snapshot: the counters, `entity_bus_out` and `frame_start` all change on the same edge.
- Full frame with `pix_en`=1 continuously is 420000 clocks between `frame_start` pulses.

## Test plan
- Reset values: assert `reset`=0 mid-frame with `entity_bus_in` = random and `colour_in`=1 → `counter_H`=`counter_V`=0, `hsync`=`vsync`=1, `display_on`=`pixel_out`=0, `entity_bus_out`=88'hFF..F, no `frame_start` after release.
- Horizontal timing, `pix_en`=1, default params: `hsync` falls 656+2 clocks after the (0,0) line start, stays low 96 clocks; `line_end` high at `counter_H`=799; `counter_V` increments the next clock.
- Frame wrap: run 420000 clocks → `frame_start` pulses exactly once with counters (0,0); `vsync` low for 1600 clocks, beginning 2 clocks after `counter_V` reaches 490.
- Snapshot: change `entity_bus_in` at `counter_V`=100 → `entity_bus_out` unchanged until the (0,0) edge, then equals the new value.
- `pix_en` stall: drop `pix_en` for 10 clocks at (320,200) → counters hold at (320,200); `display_on` stays 1; resuming advances to 321 on the first enabled clock.
- Pipeline alignment with PIPE_DELAY=3: `colour_in` tied to (counter_H==0) delayed 3 clocks → `pixel_out`=1 exactly on the first `display_on` clock of each visible line, 0 on all others.
